// File: rtl/hid_key_event_gen.sv
// rtl/hid_key_event_gen.sv - diffs HID reports into ordered make/break events with typematic repeat
module hid_key_event_gen #(
    parameter int NUM_KEYS     = 6,
    parameter int FIFO_DEPTH   = 16,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 24000000,
    parameter int REPEAT_RATE  = 2400000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  report_valid,
    input  logic [7:0]            report_mod,
    input  logic [8*NUM_KEYS-1:0] report_keys,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [7:0]            evt_code,
    output logic                  evt_pressed,
    output logic                  evt_repeat,
    output logic                  busy,
    output logic                  report_drop
);

    localparam int E  = 8 + NUM_KEYS;
    localparam int IW = $clog2(E);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_MAK, S_COMMIT} state_t;

    state_t                  state, state_nx;
    logic [IW-1:0]           idx, idx_nx;

    logic [7:0]              cur_mod, prev_mod, pend_mod;
    logic [8*NUM_KEYS-1:0]   cur_keys, prev_keys, pend_keys;
    logic                    pend_valid;
    logic [7:0]              cur_k  [NUM_KEYS];
    logic [7:0]              prev_k [NUM_KEYS];
    logic [NUM_KEYS-1:0]     brk_slot, mak_slot;

    logic                    rollover, new_rep;
    logic                    ent_brk, ent_mak;
    logic [7:0]              brk_code, mak_code;
    logic                    scan_need, scan_push, scan_pressed;
    logic [7:0]              scan_code;

    logic [9:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic                    fifo_pop, fifo_push, can_push;
    logic [9:0]              fifo_wdata;

    logic                    rpt_active, rpt_first, rpt_due, rpt_push, rpt_ok;
    logic [7:0]              rpt_code;
    logic [31:0]             rpt_timer, rpt_term;

    // Unpack usage slots and flag ErrorRollOver reports
    always_comb begin
        rollover = 1'b0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            cur_k[j]  = cur_keys[j*8 +: 8];
            prev_k[j] = prev_keys[j*8 +: 8];
            if (report_keys[j*8 +: 8] == 8'h01) rollover = 1'b1;
        end
    end

    assign new_rep = report_valid && !rollover;

    // Per-slot break/make candidates; duplicates defer to the lowest slot
    always_comb begin
        for (int j = 0; j < NUM_KEYS; j++) begin
            brk_slot[j] = (prev_k[j] != 8'h00);
            mak_slot[j] = (cur_k[j] != 8'h00);
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (cur_k[k] == prev_k[j]) brk_slot[j] = 1'b0;
                if (prev_k[k] == cur_k[j]) mak_slot[j] = 1'b0;
                if (k < j && prev_k[k] == prev_k[j]) brk_slot[j] = 1'b0;
                if (k < j && cur_k[k] == cur_k[j]) mak_slot[j] = 1'b0;
            end
        end
    end

    // Select the entry addressed by the scan index
    always_comb begin
        brk_code = 8'hE0 | {5'd0, idx[2:0]};
        mak_code = 8'hE0 | {5'd0, idx[2:0]};
        ent_brk  = prev_mod[idx[2:0]] & ~cur_mod[idx[2:0]];
        ent_mak  = cur_mod[idx[2:0]] & ~prev_mod[idx[2:0]];
        if (idx >= IW'(8)) begin
            ent_brk = 1'b0;
            ent_mak = 1'b0;
            for (int j = 0; j < NUM_KEYS; j++) begin
                if (idx == IW'(j + 8)) begin
                    brk_code = prev_k[j];
                    mak_code = cur_k[j];
                    ent_brk  = brk_slot[j];
                    ent_mak  = mak_slot[j];
                end
            end
        end
    end

    assign scan_pressed = (state == S_MAK);
    assign scan_code    = scan_pressed ? mak_code : brk_code;
    assign scan_need    = (state == S_BRK && ent_brk) || (state == S_MAK && ent_mak);
    assign fifo_pop     = evt_valid && evt_ready;
    assign can_push     = (count != CW'(FIFO_DEPTH)) || fifo_pop;
    assign scan_push    = scan_need && can_push;

    // Scan sequencing: advance one entry per cycle unless a push is blocked
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            S_IDLE: begin
                if (new_rep) begin
                    state_nx = S_BRK;
                    idx_nx   = '0;
                end
            end
            S_BRK, S_MAK: begin
                if (!(scan_need && !can_push)) begin
                    if (idx == IW'(E - 1)) begin
                        state_nx = (state == S_BRK) ? S_MAK : S_COMMIT;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end
            end
            S_COMMIT: begin
                idx_nx   = '0;
                state_nx = (pend_valid || new_rep) ? S_BRK : S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    // FSM state and scan index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Report capture, pending slot, commit of the scanned report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_mod     <= '0;
            cur_keys    <= '0;
            prev_mod    <= '0;
            prev_keys   <= '0;
            pend_mod    <= '0;
            pend_keys   <= '0;
            pend_valid  <= 1'b0;
            report_drop <= 1'b0;
        end else if (state == S_IDLE) begin
            if (new_rep) begin
                cur_mod  <= report_mod;
                cur_keys <= report_keys;
            end
        end else if (state == S_COMMIT) begin
            prev_mod  <= cur_mod;
            prev_keys <= cur_keys;
            if (pend_valid) begin
                cur_mod    <= pend_mod;
                cur_keys   <= pend_keys;
                pend_valid <= new_rep;
                if (new_rep) begin
                    pend_mod  <= report_mod;
                    pend_keys <= report_keys;
                end
            end else if (new_rep) begin
                cur_mod  <= report_mod;
                cur_keys <= report_keys;
            end
        end else if (new_rep) begin
            pend_mod   <= report_mod;
            pend_keys  <= report_keys;
            pend_valid <= 1'b1;
            if (pend_valid) report_drop <= 1'b1;
        end
    end

    assign rpt_ok   = (REPEAT_EN != 0) && (scan_code >= 8'h04) && (scan_code <= 8'hDF);
    assign rpt_term = rpt_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1);
    assign rpt_due  = rpt_active && (rpt_timer == rpt_term);
    assign rpt_push = rpt_due && !scan_push && can_push;

    // Typematic target and timer; a blocked repeat holds at terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_active <= 1'b0;
            rpt_first  <= 1'b0;
            rpt_code   <= '0;
            rpt_timer  <= '0;
        end else if (scan_push && scan_pressed && rpt_ok) begin
            rpt_active <= 1'b1;
            rpt_first  <= 1'b1;
            rpt_code   <= scan_code;
            rpt_timer  <= '0;
        end else if (scan_push && !scan_pressed && rpt_active && scan_code == rpt_code) begin
            rpt_active <= 1'b0;
        end else if (rpt_push) begin
            rpt_first <= 1'b0;
            rpt_timer <= '0;
        end else if (rpt_active && !rpt_due) begin
            rpt_timer <= rpt_timer + 32'd1;
        end
    end

    assign fifo_push  = scan_push || rpt_push;
    assign fifo_wdata = scan_push ? {scan_code, scan_pressed, 1'b0} : {rpt_code, 2'b11};

    // Event FIFO storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                mem[wr_ptr] <= fifo_wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign evt_valid                          = (count != '0);
    assign {evt_code, evt_pressed, evt_repeat} = mem[rd_ptr];
    assign busy                               = (state != S_IDLE);

endmodule

// File: tb/tb_hid_key_event_gen.sv
// tb/tb_hid_key_event_gen.sv - scoreboard bench for hid_key_event_gen
module tb_hid_key_event_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        report_valid = 1'b0;
    logic [7:0]  report_mod = '0;
    logic [47:0] report_keys = '0;
    logic        evt_valid, evt_ready, evt_pressed, evt_repeat, busy, report_drop;
    logic [7:0]  evt_code;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [9:0]  exp_q[$];
    int          pop_times[$];
    logic [9:0]  mon_got, mon_exp;

    typedef struct {
        logic [7:0] mod;
        logic [7:0] k0, k1, k2;
        int         n;
        logic [9:0] ev [4];
    } vec_t;
    vec_t tbl [6];

    hid_key_event_gen #(
        .NUM_KEYS(6), .FIFO_DEPTH(4), .REPEAT_EN(1), .REPEAT_DELAY(100), .REPEAT_RATE(20)
    ) dut (
        .clk(clk), .reset(reset), .report_valid(report_valid), .report_mod(report_mod),
        .report_keys(report_keys), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_pressed(evt_pressed), .evt_repeat(evt_repeat),
        .busy(busy), .report_drop(report_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] ev(input logic [7:0] code, input logic p, input logic r);
        return {code, p, r};
    endfunction

    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            mon_got = {evt_code, evt_pressed, evt_repeat};
            pop_times.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got code=%h pressed=%b repeat=%b, required no event",
                         evt_code, evt_pressed, evt_repeat);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL evt_order: got code=%h pressed=%b repeat=%b, required code=%h pressed=%b repeat=%b",
                             mon_got[9:2], mon_got[1], mon_got[0], mon_exp[9:2], mon_exp[1], mon_exp[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic send(input logic [7:0] m, input logic [7:0] k0, input logic [7:0] k1,
                        input logic [7:0] k2, input logic [7:0] k3, input logic [7:0] k4,
                        input logic [7:0] k5);
        @(posedge clk); #1;
        report_mod   = m;
        report_keys  = {k5, k4, k3, k2, k1, k0};
        report_valid = 1'b1;
        @(posedge clk); #1;
        report_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while ((busy || evt_valid || exp_q.size() != 0) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending events after %0d cycles, required 0", name, exp_q.size(), max);
            exp_q.delete();
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] m, input logic [7:0] k0, input logic [7:0] k1,
                           input logic [7:0] k2, input int n, input logic [9:0] e0, input logic [9:0] e1,
                           input logic [9:0] e2, input logic [9:0] e3);
        tbl[i].mod = m; tbl[i].k0 = k0; tbl[i].k1 = k1; tbl[i].k2 = k2; tbl[i].n = n;
        tbl[i].ev[0] = e0; tbl[i].ev[1] = e1; tbl[i].ev[2] = e2; tbl[i].ev[3] = e3;
    endtask

    initial begin
        set_vec(0, 8'h00, 8'h04, 8'h00, 8'h00, 1, ev(8'h04, 1, 0), '0, '0, '0);
        set_vec(1, 8'h00, 8'h00, 8'h00, 8'h00, 1, ev(8'h04, 0, 0), '0, '0, '0);
        set_vec(2, 8'h02, 8'h05, 8'h00, 8'h00, 2, ev(8'hE1, 1, 0), ev(8'h05, 1, 0), '0, '0);
        set_vec(3, 8'h01, 8'h06, 8'h00, 8'h00, 4, ev(8'hE1, 0, 0), ev(8'h05, 0, 0), ev(8'hE0, 1, 0), ev(8'h06, 1, 0));
        set_vec(4, 8'h01, 8'h0B, 8'h0A, 8'h0B, 3, ev(8'h06, 0, 0), ev(8'h0B, 1, 0), ev(8'h0A, 1, 0), '0);
        set_vec(5, 8'h00, 8'h00, 8'h00, 8'h00, 3, ev(8'hE0, 0, 0), ev(8'h0B, 0, 0), ev(8'h0A, 0, 0), '0);

        evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_evt_valid", 32'(evt_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_drop", 32'(report_drop), 0);
        chk("reset_evt_code", 32'(evt_code), 0);
        reset = 1'b0;

        // table: basic make/break, ordering, duplicate slots
        for (int i = 0; i < 6; i++) begin
            for (int e = 0; e < tbl[i].n; e++) exp_q.push_back(tbl[i].ev[e]);
            send(tbl[i].mod, tbl[i].k0, tbl[i].k1, tbl[i].k2, 8'h00, 8'h00, 8'h00);
            wait_idle($sformatf("table%0d", i), 200);
        end

        // typematic: make, repeats at +100/+120/+140, then release stops them
        pop_times.delete();
        exp_q.push_back(ev(8'h04, 1, 0));
        repeat (3) exp_q.push_back(ev(8'h04, 1, 1));
        send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle("repeat", 400);
        exp_q.push_back(ev(8'h04, 0, 0));
        send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle("repeat_release", 100);
        repeat (150) @(posedge clk);
        #1;
        chk("repeat_count", 32'(pop_times.size()), 5);
        if (pop_times.size() >= 4) begin
            chk("repeat_first", 32'(pop_times[1] - pop_times[0]), 100);
            chk("repeat_second", 32'(pop_times[2] - pop_times[0]), 120);
            chk("repeat_third", 32'(pop_times[3] - pop_times[0]), 140);
        end

        // backpressure: FIFO of 4 stalls the scan, nothing lost
        evt_ready = 1'b0;
        for (int k = 4; k <= 9; k++) exp_q.push_back(ev(8'(k), 1, 0));
        send(8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
        repeat (30) @(posedge clk);
        #1;
        chk("stall_busy", 32'(busy), 1);
        chk("stall_valid", 32'(evt_valid), 1);
        chk("stall_head", 32'(evt_code), 32'h04);
        evt_ready = 1'b1;
        wait_idle("stall_drain", 100);
        for (int k = 4; k <= 9; k++) exp_q.push_back(ev(8'(k), 0, 0));
        send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle("stall_release", 100);

        // overwritten pending reports: only the last applies
        exp_q.push_back(ev(8'h04, 1, 0));
        exp_q.push_back(ev(8'h04, 0, 0));
        exp_q.push_back(ev(8'h07, 1, 0));
        send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send(8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("drop_sticky", 32'(report_drop), 1);
        wait_idle("drop", 200);

        // ErrorRollOver report ignored; prev still {07}
        send(8'h00, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rollover_busy", 32'(busy), 0);
        chk("rollover_valid", 32'(evt_valid), 0);
        send(8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle("rollover_same", 100);
        exp_q.push_back(ev(8'h07, 0, 0));
        send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle("rollover_release", 100);

        // reset in the middle of a scan
        evt_ready = 1'b0;
        send(8'h00, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00);
        begin
            int n = 0;
            while (!evt_valid && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            chk("midscan_has_event", 32'(evt_valid), 1);
        end
        chk("midscan_busy_before", 32'(busy), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midscan_evt_valid", 32'(evt_valid), 0);
        chk("midscan_busy", 32'(busy), 0);
        chk("midscan_drop_cleared", 32'(report_drop), 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        evt_ready = 1'b1;
        for (int k = 4; k <= 6; k++) exp_q.push_back(ev(8'(k), 1, 0));
        send(8'h00, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00);
        wait_idle("midscan_resend", 100);
        for (int k = 4; k <= 6; k++) exp_q.push_back(ev(8'(k), 0, 0));
        send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle("midscan_release", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
